// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, line-level constants and the hex-digit helper.
// Used by a0_uart_tx (and its hex build, enabled by macro A0_UART_HEX_EN).
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam logic       START_BIT     = 1'b0;
    localparam logic       STOP_BIT      = 1'b1;
    localparam int         BITS_PER_BYTE = 8;
    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_A       = 8'h41;
    localparam logic [7:0] ASCII_NL      = 8'h0A;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? ASCII_0 + {4'h0, n} : ASCII_A + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/a0_fifo.sv
// a0_fifo: circular-buffer synchronous FIFO, asynchronous active-low reset.
// Ports: clk_i, rst_i (active-low), push_i/wdata_i write side, pop_i/rdata_o read
// side (rdata_o shows the head word), full_o, empty_o, count_o occupancy.
// The caller must not push while full unless it pops in the same cycle.
module a0_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d = mem_q;
        if (push_i) mem_d[wr_q] = wdata_i;
        wr_d  = wr_q + PTR_W'(push_i);
        rd_d  = rd_q + PTR_W'(pop_i);
        cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = cnt_q == CNT_W'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/a0_uart_tx.sv
// a0_uart_tx: queues every change of a0_i and serialises each word onto an 8N1 line.
// Ports: clk_i, rst_i (async active-low), a0_i monitored value, en_i capture enable,
// clr_ovf_i overflow clear, tx_o serial line, busy_o serialiser active,
// overflow_o sticky drop flag, fifo_count_o queue occupancy.
// Macro A0_UART_HEX_EN: send each word as uppercase ASCII hex plus newline
// instead of raw bytes (most significant first in both modes).
module a0_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         a0_i,
    input  logic                          en_i,
    input  logic                          clr_ovf_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

`ifdef A0_UART_HEX_EN
    localparam int NUNITS = DATA_WIDTH / 4 + 1;
    localparam int SHIFT  = 4;
`else
    localparam int NUNITS = DATA_WIDTH / 8;
    localparam int SHIFT  = 8;
`endif
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int UNIT_W = $clog2(NUNITS) + 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [UNIT_W-1:0]     unit_q, unit_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic                  ovf_q, ovf_d;
    logic                  tx_q, tx_d;
    logic                  push_req, push, pop, full, empty;
    logic                  last_tick, last_unit;
    logic [DATA_WIDTH-1:0] rdata;
    logic [7:0]            cur_char;

    a0_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (a0_i),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count_o)
    );

    // A full FIFO still accepts a push when the serialiser pops in the same cycle.
    always_comb begin
        last_d   = a0_i;
        push_req = en_i && (a0_i != last_q);
        push     = push_req && (!full || pop);
        ovf_d    = (push_req && !push) ? 1'b1 : clr_ovf_i ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            unit_q  <= '0;
            word_q  <= '0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= STOP_BIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            unit_q  <= unit_d;
            word_q  <= word_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
        end
    end

    assign last_tick = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
    assign last_unit = unit_q == UNIT_W'(NUNITS - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = last_tick ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        unit_d  = unit_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pop) begin
                    word_d  = rdata;
                    unit_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (last_tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last_tick) begin
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 3'(BITS_PER_BYTE - 1)) ? STOP : DATA;
                end
            end
            STOP: begin
                if (last_tick) begin
                    // Next character follows straight away; only the last one returns to IDLE.
                    state_d = last_unit ? IDLE : START;
                    unit_d  = last_unit ? unit_q : unit_q + 1'b1;
                    word_d  = last_unit ? word_q : word_q << SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered, so the line lags the state by one cycle and never glitches.
    always_comb begin
        busy_o = state_q != IDLE;
        pop    = (state_q == IDLE) && !empty;
`ifdef A0_UART_HEX_EN
        cur_char = last_unit ? ASCII_NL : hex_ascii(word_q[DATA_WIDTH-1 -: 4]);
`else
        cur_char = word_q[DATA_WIDTH-1 -: 8];
`endif
        tx_d = (state_q == START) ? START_BIT :
               (state_q == DATA)  ? cur_char[bit_q] : STOP_BIT;
    end

    assign tx_o       = tx_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_a0_uart_tx.sv
// tb_a0_uart_tx: directed bench for a0_uart_tx with a line-level UART decoder.
module tb_a0_uart_tx;

    localparam int CPB = 4;
`ifdef A0_UART_HEX_EN
    localparam int UNITS = 9;
    localparam logic [31:0] W1 = 32'hDEADBEEF;
`else
    localparam int UNITS = 4;
    localparam logic [31:0] W1 = 32'h12345678;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a0 = '0;
    logic        en = 1'b1;
    logic        clr = 1'b0;
    logic        tx_o, busy_o, overflow_o;
    logic [2:0]  fifo_count_o;

    int n_vec = 0;
    int n_err = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] a0;
        logic        en;
        logic        clr;
        logic [2:0]  cnt;
        logic        ovf;
        logic        busy;
    } vec_t;
    vec_t tbl[10];

    a0_uart_tx #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .a0_i         (a0),
        .en_i         (en),
        .clr_ovf_i    (clr),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .overflow_o   (overflow_o),
        .fifo_count_o (fifo_count_o)
    );

    always #5 clk = ~clk;

    // Line decoder: samples each bit near its middle on falling clock edges.
    initial begin : mon
        logic [7:0] b;
        logic       stp;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_o === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_o;
                end
                repeat (CPB) @(negedge clk);
                stp = tx_o;
                rx_q.push_back(b);
                if (stp !== 1'b1) frame_err++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_exp(input logic [31:0] w);
`ifdef A0_UART_HEX_EN
        for (int i = 0; i < 8; i++) begin
            logic [3:0] n;
            n = w[31-4*i -: 4];
            exp_q.push_back(n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n});
        end
        exp_q.push_back(8'h0A);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(w[31-8*i -: 8]);
`endif
    endtask

    task automatic cmp_rx(input string nm);
        chk({nm, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_b%0d", nm, i), 64'(rx_q[i]), 64'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy_o || fifo_count_o != 0) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles", maxc);
        end
        repeat (30) tick();
    endtask

    initial begin
        int bc, low;
        tbl[0] = '{32'h01020304, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
        tbl[1] = '{32'h05060708, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1};
        tbl[2] = '{32'h090A0B0C, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1};
        tbl[3] = '{32'h0D0E0F10, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1};
        tbl[4] = '{32'h11121314, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};
        tbl[5] = '{32'h15161718, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1};
        tbl[6] = '{32'h15161718, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1};
        tbl[7] = '{32'h191A1B1C, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1};
        tbl[8] = '{32'h191A1B1C, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1};
        tbl[9] = '{32'h191A1B1C, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};

        // Reset
        repeat (3) tick();
        chk("rst_tx_held", 64'(tx_o), 64'd1);
        rst_n = 1'b1;
        tick();
        chk("rst_tx", 64'(tx_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_cnt", 64'(fifo_count_o), 64'd0);
        low = 0;
        repeat (100) begin
            tick();
            if (tx_o !== 1'b1 || busy_o !== 1'b0) low++;
        end
        chk("rst_quiet", 64'(low), 64'd0);

        // Single word: push at N, pop at N+1, tx low at N+2
        a0 = W1;
        tick();
        chk("sw_cnt_N", 64'(fifo_count_o), 64'd1);
        chk("sw_busy_N", 64'(busy_o), 64'd0);
        chk("sw_tx_N", 64'(tx_o), 64'd1);
        tick();
        chk("sw_busy_N1", 64'(busy_o), 64'd1);
        chk("sw_tx_N1", 64'(tx_o), 64'd1);
        chk("sw_cnt_N1", 64'(fifo_count_o), 64'd0);
        tick();
        chk("sw_tx_N2", 64'(tx_o), 64'd0);
        bc = 2;
        for (int i = 0; i < 1000 && busy_o; i++) begin
            tick();
            if (busy_o) bc++;
        end
        chk("sw_busy_len", 64'(bc), 64'(UNITS * 10 * CPB));
        repeat (30) tick();
`ifdef A0_UART_HEX_EN
        exp_q = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
`else
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
`endif
        cmp_rx("sw");

        // Overflow and clear, one table row per cycle
        for (int i = 0; i < 10; i++) begin
            a0  = tbl[i].a0;
            en  = tbl[i].en;
            clr = tbl[i].clr;
            tick();
            chk($sformatf("ovf_row%0d", i), {61'd0, fifo_count_o, overflow_o, busy_o},
                {61'd0, tbl[i].cnt, tbl[i].ovf, tbl[i].busy});
        end
        clr = 1'b0;
        for (int i = 0; i < 5; i++) add_exp(tbl[i].a0);
        wait_idle(5000);
        cmp_rx("ovf");

        // Enable gating
        en = 1'b0;
        a0 = 32'h000000AA;
        tick();
        chk("gate_cnt0", 64'(fifo_count_o), 64'd0);
        en = 1'b1;
        tick();
        chk("gate_cnt1", 64'(fifo_count_o), 64'd0);
        chk("gate_busy", 64'(busy_o), 64'd0);
        repeat (100) tick();
        cmp_rx("gate");

        // Asynchronous reset during a data bit of the second character
        a0 = 32'hC0FEF00D;
        tick();
        a0 = 32'h00000011;
        tick();
        a0 = 32'h00000022;
        tick();
        repeat (44) tick();
        chk("mf_cnt_pre", 64'(fifo_count_o), 64'd2);
        chk("mf_tx_pre", 64'(tx_o), 64'd0);
        #1;
        rst_n = 1'b0;
        a0 = '0;
        #1;
        chk("mf_tx", 64'(tx_o), 64'd1);
        chk("mf_busy", 64'(busy_o), 64'd0);
        chk("mf_cnt", 64'(fifo_count_o), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        rx_q.delete();
        low = 0;
        repeat (200) begin
            tick();
            if (tx_o !== 1'b1 || busy_o !== 1'b0) low++;
        end
        chk("mf_quiet", 64'(low), 64'd0);
        cmp_rx("mf");
        chk("framing", 64'(frame_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
